hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline hazard controller. Drives the stall/flush inputs of the IF/ID and ID/EX registers and the PC enable.
//   Resolves load-use hazards, taken-branch redirects, instruction-memory wait and multi-cycle mul/div occupancy.
//   Sits beside the 5-stage datapath. The only state is a small FSM and a mul/div latency counter.
// PARAMETERS
//   MD_LAT   4   cycles a mul/div occupies E (>=2); E held for MD_LAT-1 extra cycles
//   CNT_W    32  width of performance counters (used only with HAZARD_PERF_EN)
// PORTS
//   CLK           in   1  clock, rising edge
//   reset         in   1  asynchronous, active-low reset
//   rs1D, rs2D    in   5  source regs of instruction in D
//   rdE           in   5  dest reg of instruction in E
//   memReadE      in   1  instruction in E is a load
//   pcSrcE        in   1  branch/jump taken in E (redirect)
//   mdStartE      in   1  instruction in E is mul/div, first E cycle
//   imemReady     in   1  fetch data valid this cycle
//   stallF        out  1  1 = hold PC
//   stallD        out  1  1 = hold IF/ID
//   flushD        out  1  1 = clear IF/ID
//   stallE        out  1  1 = hold ID/EX
//   flushE        out  1  1 = clear ID/EX
//   flushM        out  1  1 = inject bubble into EX/MEM
//   mdBusy        out  1  FSM in MD_WAIT
//   stallCnt      out  CNT_W  cycles with stallF=1   (HAZARD_PERF_EN only)
//   flushCnt      out  CNT_W  cycles with flushD|flushE=1 (HAZARD_PERF_EN only)
// BEHAVIOUR
//   Reset (reset=0, async): state=RUN, mdCnt=0, perf counters=0; all outputs 0 while reset low.
//   FSM states: RUN, MD_WAIT.
//     RUN->MD_WAIT on mdStartE=1 && pcSrcE=0; mdCnt <= MD_LAT-2.
//     MD_WAIT: mdCnt decrements each cycle; ->RUN on the edge where mdCnt==0.
//   MD_WAIT outputs: stallF=stallD=stallE=1, flushM=1, flushD=flushE=0; all other inputs ignored.
//     E is therefore held for exactly MD_LAT-1 cycles after the mdStartE cycle.
//   RUN outputs (combinational, zero latency), priority high->low:
//     1 pcSrcE=1: flushD=1, flushE=1, no stalls; load-use and imem wait suppressed.
//     2 load-use: memReadE && rdE!=0 && (rdE==rs1D || rdE==rs2D) -> stallF=stallD=1, flushE=1.
//     3 imemReady=0: stallF=1, flushD=1 (bubble into D).
//       If load-use holds the same cycle, rule 2 applies and flushD=0; stallD wins over flushD.
//     4 otherwise all 0.
//   rdE==0 never produces a load-use stall. The mdStartE cycle itself uses the RUN rules.
//   stallX and flushX for the same register are never both 1.
//   Reset asserted mid MD_WAIT aborts the operation; FSM is in RUN on release.
// CONFIGURATION
//   HAZARD_PERF_EN defined:
//     stallCnt increments on every cycle with stallF=1.
//     flushCnt increments on every cycle with (flushD|flushE)=1.
//     Both wrap modulo 2^CNT_W.
//   HAZARD_PERF_EN undefined: stallCnt/flushCnt ports absent, no counter logic.
// STRUCTURE
//   hazard_pkg: state enum (RUN, MD_WAIT); MD_LAT_DEFAULT=4; REG_ZERO=5'd0; helper function ld_use(rs1, rs2, rd, memRead).
//   Sub-module hazard_perf_ctr (CNT_W-bit enable counter, async active-low clear); two instances under HAZARD_PERF_EN.
//   Top holds the FSM, mdCnt ($clog2(MD_LAT) bits) and the output priority mux.
// TESTING
//   1 memReadE=1, rdE=5, rs1D=5 -> stallF=stallD=flushE=1 for 1 cycle; rdE=0, rs2D=0 -> no stall.
//   2 pcSrcE=1 with concurrent load-use and imemReady=0 -> flushD=flushE=1, stallF=stallD=0.
//   3 mdStartE=1 pulse, MD_LAT=4 -> mdBusy=1 and stallF=stallD=stallE=flushM=1 for exactly 3 cycles; RUN on the 4th.
//   4 reset driven low on 2nd MD_WAIT cycle (off-edge) -> outputs 0 immediately; state RUN, mdBusy=0 after release.
//   5 imemReady=0 for 3 cycles -> stallF=flushD=1 for 3 cycles; same with load-use active -> flushD=0, stallD=1.
//   6 HAZARD_PERF_EN, CNT_W=4: 17 stall cycles -> stallCnt=1 (wrap); flushCnt counts scenario-2 cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and helpers for the pipeline hazard controller.
//   - state_e        : controller FSM states (RUN, MD_WAIT)
//   - MD_LAT_DEFAULT : default mul/div occupancy of the E stage, in cycles
//   - REG_ZERO       : architectural x0, never a real dependency
//   - ld_use()       : load-use dependency between the load in E and the
//                      instruction in D
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam int         MD_LAT_DEFAULT = 4;
  localparam logic [4:0] REG_ZERO       = 5'd0;

  // A load in E whose destination is read by the instruction in D cannot
  // be forwarded in time. Writes to x0 are discarded, so they never count.
  function automatic logic ld_use(input logic [4:0] rs1,
                                  input logic [4:0] rs2,
                                  input logic [4:0] rd,
                                  input logic       mem_read);
    return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_perf_ctr.sv
// -----------------------------------------------------------------------------
// hazard_perf_ctr
//   Free-running event counter that wraps modulo 2^CNT_W.
//   Ports:
//     clk_i   in   clock, rising edge
//     rst_ni  in   asynchronous active-low clear
//     en_i    in   count this cycle
//     cnt_o   out  current count
// -----------------------------------------------------------------------------
module hazard_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for a 5-stage pipeline. Generates PC enable and the
//   stall/flush controls of IF/ID, ID/EX and EX/MEM from load-use hazards,
//   taken-branch redirects, instruction-memory wait and mul/div occupancy.
//
//   Optional feature macro: HAZARD_PERF_EN adds the CNT_W parameter and the
//   stallCnt / flushCnt performance counter outputs.
//
//   Ports:
//     CLK        in   clock, rising edge
//     reset      in   asynchronous active-low reset
//     rs1D/rs2D  in   source registers of the instruction in D
//     rdE        in   destination register of the instruction in E
//     memReadE   in   instruction in E is a load
//     pcSrcE     in   taken branch/jump in E
//     mdStartE   in   first E cycle of a mul/div
//     imemReady  in   fetch data valid this cycle
//     stallF     out  hold PC
//     stallD     out  hold IF/ID
//     flushD     out  clear IF/ID
//     stallE     out  hold ID/EX
//     flushE     out  clear ID/EX
//     flushM     out  bubble into EX/MEM
//     mdBusy     out  FSM is in MD_WAIT (FSM state observation point)
//     stallCnt   out  cycles with stallF=1          (HAZARD_PERF_EN only)
//     flushCnt   out  cycles with flushD|flushE=1   (HAZARD_PERF_EN only)
//
//   The control outputs have no handshake: they are level signals valid in
//   the same cycle as the inputs that cause them.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdE,
  input  logic             memReadE,
  input  logic             pcSrcE,
  input  logic             mdStartE,
  input  logic             imemReady,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             stallE,
  output logic             flushE,
  output logic             flushM,
  output logic             mdBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
`endif
);

  localparam int             MDW     = $clog2(MD_LAT);
  // The start cycle runs under RUN rules, so MD_WAIT lasts MD_LAT-1 cycles:
  // the counter is loaded with MD_LAT-2 and leaves on the edge where it is 0.
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LAT - 2);
  localparam logic [MDW-1:0] MD_ONE  = MDW'(1);

  state_e         state_q, state_d;
  logic [MDW-1:0] md_cnt_q, md_cnt_d;
  logic           load_use;

  assign load_use = ld_use(rs1D, rs2D, rdE, memReadE);

  // Next state. A mul/div squashed by a redirect in the same cycle never
  // occupies E, so it does not start the wait.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (mdStartE && !pcSrcE) begin
          state_d  = MD_WAIT;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_WAIT: begin
        if (md_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - MD_ONE;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Output priority mux. RUN decisions are zero-latency; everything is
  // forced low while reset is asserted, independent of the clock.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    stallE = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (!reset) begin
      stallF = 1'b0;
    end else if (state_q == MD_WAIT) begin
      // Freeze F, D and E around the busy unit; M receives bubbles.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (pcSrcE) begin
      // Wrong-path instructions in D and E are discarded; stalling them
      // would only keep dead work alive.
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in D and send a bubble into E. This also covers
      // a concurrent imem wait: D must keep its instruction, not be cleared.
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (!imemReady) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end
  end

  assign mdBusy = (state_q == MD_WAIT);

`ifdef HAZARD_PERF_EN
  hazard_perf_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk_i  (CLK),
    .rst_ni (reset),
    .en_i   (stallF),
    .cnt_o  (stallCnt)
  );

  hazard_perf_ctr #(
    .CNT_W (CNT_W)
  ) u_flush_ctr (
    .clk_i  (CLK),
    .rst_ni (reset),
    .en_i   (flushD | flushE),
    .cnt_o  (flushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. A behavioural model tracks how many
//   mul/div hold cycles remain and derives the expected control vector from
//   the hazard rules each cycle; directed steps add literal expectations.
//   Output vector order: {stallF, stallD, flushD, stallE, flushE, flushM, mdBusy}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;
`ifdef HAZARD_PERF_EN
  localparam int CNT_W  = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1D = '0, rs2D = '0, rdE = '0;
  logic memReadE = 1'b0, pcSrcE = 1'b0, mdStartE = 1'b0, imemReady = 1'b1;
  logic stallF, stallD, flushD, stallE, flushE, flushM, mdBusy;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  logic [6:0] dut_outs;
  assign dut_outs = {stallF, stallD, flushD, stallE, flushE, flushM, mdBusy};

  hazard_ctrl #(
    .MD_LAT (MD_LAT)
`ifdef HAZARD_PERF_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) dut (
    .CLK       (clk),
    .reset     (reset_n),
    .rs1D      (rs1D),
    .rs2D      (rs2D),
    .rdE       (rdE),
    .memReadE  (memReadE),
    .pcSrcE    (pcSrcE),
    .mdStartE  (mdStartE),
    .imemReady (imemReady),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .stallE    (stallE),
    .flushE    (flushE),
    .flushM    (flushM),
    .mdBusy    (mdBusy)
`ifdef HAZARD_PERF_EN
    ,
    .stallCnt  (stall_cnt),
    .flushCnt  (flush_cnt)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int md_rem    = 0;  // mul/div hold cycles still owed
  int exp_stall = 0;
  int exp_flush = 0;

  function automatic logic [6:0] model_outs();
    logic lu;
    lu = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    if (!reset_n)        return 7'b0000000;
    if (md_rem > 0)      return 7'b1101011;
    if (pcSrcE)          return 7'b0010100;
    if (lu)              return 7'b1100100;
    if (!imemReady)      return 7'b1010000;
    return 7'b0000000;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model_step
    logic [6:0] cur;
    if (!reset_n) begin
      md_rem    <= 0;
      exp_stall <= 0;
      exp_flush <= 0;
    end else begin
      cur = model_outs();
      if (cur[6])          exp_stall <= exp_stall + 1;
      if (cur[4] | cur[2]) exp_flush <= exp_flush + 1;
      if (md_rem > 0)                   md_rem <= md_rem - 1;
      else if (mdStartE && !pcSrcE)     md_rem <= MD_LAT - 1;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [6:0] exp_q[$];

  always @(negedge clk) begin
    exp_q.push_back(model_outs());
    check("outs", 32'(dut_outs), 32'(exp_q.pop_front()));
`ifdef HAZARD_PERF_EN
    check("stallCnt", 32'(stall_cnt), 32'(exp_stall % (1 << CNT_W)));
    check("flushCnt", 32'(flush_cnt), 32'(exp_flush % (1 << CNT_W)));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                       input logic mr, input logic pc, input logic md, input logic im);
    @(posedge clk);
    #1;
    rs1D = s1; rs2D = s2; rdE = rd;
    memReadE = mr; pcSrcE = pc; mdStartE = md; imemReady = im;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic lit(input string name, input logic [6:0] exp);
    #1;
    check(name, 32'(dut_outs), 32'(exp));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(dut_outs), 32'd0);
    #2 reset_n = 1'b1;

    // load-use on rs1, then x0 destination
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); lit("load_use", 7'b1100100);
    drive(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); lit("rd_zero", 7'b0000000);
    drive(5'd7, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1); lit("load_use_rs2", 7'b1100100);
    idle();                                           lit("idle", 7'b0000000);

    // redirect beats load-use and imem wait
    drive(5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0); lit("branch_prio", 7'b0010100);

    // imem wait for 3 cycles, then with load-use
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); lit("imem_wait", 7'b1010000);
    end
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0); lit("imem_lu", 7'b1100100);

    // mul/div occupancy: start cycle under RUN rules, then 3 hold cycles
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); lit("md_start", 7'b0000000);
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); lit("md_ignore", 7'b1101011);
    idle();                                           lit("md_wait2", 7'b1101011);
    idle();                                           lit("md_wait3", 7'b1101011);
    idle();                                           lit("md_done", 7'b0000000);

    // mul/div squashed by redirect never enters the wait
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); lit("md_branch", 7'b0010100);
    idle();                                           lit("md_branch_next", 7'b0000000);

    // reset in the middle of MD_WAIT
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();                                           lit("md_wait_a", 7'b1101011);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("rst_mid", 32'(dut_outs), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check("rst_release_busy", 32'(mdBusy), 32'd0);
    idle();                                           lit("after_rst", 7'b0000000);

`ifdef HAZARD_PERF_EN
    // Fresh counters, then 5 mul/div ops (15 stall) + 2 imem waits
    // (2 stall, 2 flush) + 3 redirects (3 flush): stall=17 -> 1, flush=5.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) idle();
    end
    repeat (2) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    #1;
    check("perf_stall_wrap", 32'(stall_cnt), 32'd1);
    check("perf_flush", 32'(flush_cnt), 32'd5);
`endif

    repeat (2) idle();
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
